// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill engine between the I/D caches and multicycle main memory
//
// On a miss, reads the whole block that holds miss_address from main memory. One read request
// goes out per cycle, back-to-back. Each returned word is written into the data array, and then
// the tag is written. fsm_busy stays high for the whole fill so the requesting stage stalls.
//
// Ports
//   clk                in   system clock, all state updates on posedge
//   rst                in   asynchronous, active-low reset
//   miss_detected      in   level miss indication held by the cache
//   miss_address       in   byte address of the missing access
//   fsm_busy           out  fill in progress (registered)
//   mem_read           out  read request to main memory this cycle
//   memory_address     out  byte address of the current request (0 when no request)
//   memory_data_valid  in   memory_data carries a returned word this cycle
//   memory_data        in   returned word
//   write_data_array   out  write fill_data into the data array at fill_word
//   fill_word          out  word offset inside the block for this write (0 when no write)
//   fill_data          out  returned word routed to the data array (0 when no write)
//   write_tag_array    out  one-cycle pulse: write tag and set valid (registered)
//   fill_done          out  one-cycle pulse coincident with write_tag_array (registered)

module cache_fill_fsm #(
  parameter int AWIDTH      = 16,
  parameter int DWIDTH      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [AWIDTH-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           mem_read,
  output logic [AWIDTH-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [DWIDTH-1:0]              memory_data,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DWIDTH-1:0]              fill_data,
  output logic                           write_tag_array,
  output logic                           fill_done
);

  // Word index width, byte-offset width inside a block (16-bit words), and the
  // request counter width, which needs one extra bit to hold BLOCK_WORDS itself.
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = WORD_W + 1;
  localparam int CNT_W  = WORD_W + 1;

  localparam logic [CNT_W-1:0]  ISSUE_MAX = CNT_W'(BLOCK_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);
  localparam logic [AWIDTH-1:0] OFF_MASK  = AWIDTH'((1 << OFF_W) - 1);

  // The memory latency does not change this engine: it issues all requests back-to-back
  // and counts returns whenever they arrive. Only sanity-check the parameters here.
  if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block_words
    $error("cache_fill_fsm: BLOCK_WORDS must be a power of two, at least 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end
  if (AWIDTH <= OFF_W) begin : g_bad_awidth
    $error("cache_fill_fsm: AWIDTH too small for the block size");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    issue_cnt;
  logic [WORD_W-1:0]   recv_cnt;
  logic [AWIDTH-1:0]   base;

  logic                in_fill;
  logic                last_word;

  // Request and write-side outputs are combinational so a returned word is written in the
  // same cycle it is presented, and the next request goes out in the cycle after the last.
  always_comb begin
    in_fill          = (state == FILL);
    mem_read         = in_fill && (issue_cnt < ISSUE_MAX);
    write_data_array = in_fill && memory_data_valid;
    last_word        = write_data_array && (recv_cnt == LAST_WORD);

    // base has its offset bits cleared, so OR-ing the offset in can never carry
    // into the tag bits; a block near the top of memory stays inside that block.
    memory_address = '0;
    if (mem_read) begin
      memory_address = base | AWIDTH'({issue_cnt[WORD_W-1:0], 1'b0});
    end

    // fill_data follows memory_data whenever a word is being written. It is held at 0
    // otherwise, so every output is quiet while idle or in reset.
    fill_word = '0;
    fill_data = '0;
    if (write_data_array) begin
      fill_word = recv_cnt;
      fill_data = memory_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      issue_cnt       <= '0;
      recv_cnt        <= '0;
      base            <= '0;
      fsm_busy        <= 1'b0;
      write_tag_array <= 1'b0;
      fill_done       <= 1'b0;
    end else begin
      write_tag_array <= 1'b0;
      fill_done       <= 1'b0;

      case (state)
        IDLE: begin
          // Responses arriving while idle belong to nothing in flight and are dropped.
          if (miss_detected) begin
            base      <= miss_address & ~OFF_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            fsm_busy  <= 1'b1;
            state     <= FILL;
          end
        end

        FILL: begin
          // The miss inputs are not looked at here: the block address stays latched.
          // issue_cnt stops at BLOCK_WORDS because mem_read drops there.
          if (mem_read) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
          if (write_data_array) begin
            recv_cnt <= recv_cnt + WORD_W'(1);
          end
          if (last_word) begin
            write_tag_array <= 1'b1;
            fill_done       <= 1'b1;
            state           <= TAG;
          end
        end

        TAG: begin
          fsm_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          fsm_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - scoreboard testbench for cache_fill_fsm with a latency-4 memory model

module tb_cache_fill_fsm;

  localparam int BW  = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = 16'h0000;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .AWIDTH(16), .DWIDTH(16), .BLOCK_WORDS(BW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .mem_read(mem_read), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .write_data_array(write_data_array), .fill_word(fill_word), .fill_data(fill_data),
    .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    int          word;
  } ev_t;

  ev_t req_q[$];
  ev_t wr_q[$];
  int  tag_q[$];

  int  cyc        = 0;
  int  free_at    = 0;
  int  fill_start = -100;
  int  total      = 0;
  int  bad        = 0;

  logic [15:0] key = 16'hA5A5;
  logic [15:0] mbase;
  logic        req_seen = 1'b0;
  logic [15:0] req_addr_seen = 16'h0000;
  logic        pipe_v [4] = '{default: 1'b0};
  logic [15:0] pipe_a [4] = '{default: 16'h0000};
  logic        force_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected none (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: a miss seen at the edge that ends cycle c while the engine is free
  // produces requests in c+1..c+8, writes in c+1+LAT.., the tag in c+BW+LAT+1, idle after.
  always @(posedge clk) begin
    if (rst === 1'b1 && miss_detected === 1'b1 && cyc >= free_at) begin
      mbase = miss_address - (miss_address % 16);
      for (int i = 0; i < BW; i++) begin
        req_q.push_back('{cyc: cyc + 1 + i, addr: mbase + 16'(2 * i), data: 16'h0, word: 0});
        wr_q.push_back('{cyc: cyc + 1 + LAT + i, addr: mbase + 16'(2 * i),
                         data: (mbase + 16'(2 * i)) ^ key, word: i});
      end
      tag_q.push_back(cyc + BW + LAT + 1);
      fill_start = cyc;
      free_at    = cyc + BW + LAT + 2;
    end
    cyc = cyc + 1;
  end

  // Main memory: answers each observed request LAT cycles later with addr ^ key.
  always @(posedge clk) begin
    #1;
    for (int k = 3; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_a[k] = pipe_a[k-1];
    end
    pipe_v[0] = req_seen;
    pipe_a[0] = req_addr_seen;
    memory_data_valid = pipe_v[3] | force_v;
    memory_data       = pipe_v[3] ? (pipe_a[3] ^ key) : 16'($urandom);
  end

  // Monitor: pops an expectation whenever the DUT presents a request, write or tag.
  always @(negedge clk) begin
    ev_t e;
    int  t;
    req_seen      = mem_read;
    req_addr_seen = memory_address;

    if (mem_read) begin
      if (req_q.size() == 0) flag("req_unexpected", 32'(memory_address));
      else begin
        e = req_q.pop_front();
        chk("req_cycle", cyc, e.cyc);
        chk("req_addr", memory_address, e.addr);
      end
    end else begin
      chk("req_addr_quiet", memory_address, 16'h0);
    end
    while (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
      e = req_q.pop_front();
      flag("req_missing", 32'(e.addr));
    end

    if (write_data_array) begin
      if (wr_q.size() == 0) flag("write_unexpected", 32'(fill_data));
      else begin
        e = wr_q.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("fill_word", 32'(fill_word), 32'(e.word));
        chk("fill_data", fill_data, e.data);
      end
    end else begin
      chk("fill_word_quiet", 32'(fill_word), 0);
    end
    while (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      e = wr_q.pop_front();
      flag("write_missing", 32'(e.word));
    end

    if (write_tag_array) begin
      if (tag_q.size() == 0) flag("tag_unexpected", 32'(fill_done));
      else begin
        t = tag_q.pop_front();
        chk("tag_cycle", cyc, t);
        chk("fill_done_with_tag", fill_done, 1'b1);
      end
    end else begin
      chk("fill_done_quiet", fill_done, 1'b0);
    end
    while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
      t = tag_q.pop_front();
      flag("tag_missing", 32'(t));
    end

    chk("fsm_busy", fsm_busy, (cyc > fill_start) && (cyc < free_at));
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < free_at && n < 100) begin
      next_cycle();
      n++;
    end
    if (n >= 100) flag("wait_idle_timeout", 32'(cyc));
  endtask

  task automatic issue_miss(input logic [15:0] a);
    wait_idle();
    miss_address  = a;
    miss_detected = 1'b1;
    next_cycle();
    miss_detected = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 1'b0);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_addr"}, memory_address, 16'h0);
    chk({tag, "_wr"}, write_data_array, 1'b0);
    chk({tag, "_word"}, 32'(fill_word), 0);
    chk({tag, "_data"}, fill_data, 16'h0);
    chk({tag, "_tag"}, write_tag_array, 1'b0);
    chk({tag, "_done"}, fill_done, 1'b0);
  endtask

  initial begin
    int st;
    int n;
    rst           = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    repeat (3) next_cycle();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) next_cycle();

    // Miss at 0x1236, data = addr ^ 0xA5A5.
    key = 16'hA5A5;
    issue_miss(16'h1236);
    wait_idle();

    // Top-of-memory block, then a miss held through TAG starts the next fill at 0x0000.
    miss_address  = 16'hFFFE;
    miss_detected = 1'b1;
    next_cycle();
    repeat (4) next_cycle();
    miss_address = 16'h0004;
    st = fill_start;
    n  = 0;
    while (fill_start == st && n < 40) begin
      next_cycle();
      n++;
    end
    if (n >= 40) flag("back_to_back_timeout", 32'(cyc));
    miss_detected = 1'b0;
    wait_idle();

    // miss_address moves to 0x4000 mid-fill of 0x2000 while the miss stays asserted.
    miss_address  = 16'h2000;
    miss_detected = 1'b1;
    next_cycle();
    repeat (2) next_cycle();
    miss_address = 16'h4000;
    repeat (5) next_cycle();
    miss_detected = 1'b0;
    wait_idle();

    // Reset in cycle 7 of a fill; late responses must not write.
    issue_miss(16'h3458);
    repeat (6) next_cycle();
    rst = 1'b0;
    req_q.delete();
    wr_q.delete();
    tag_q.delete();
    free_at    = 0;
    fill_start = -100;
    #1;
    check_all_zero("midfill_reset");
    repeat (2) next_cycle();
    rst = 1'b1;
    repeat (8) next_cycle();
    chk("busy_after_reset", fsm_busy, 1'b0);

    // Spurious data-valid while idle, then a normal fill.
    force_v = 1'b1;
    repeat (3) next_cycle();
    force_v = 1'b0;
    next_cycle();
    chk("busy_after_idle_valid", fsm_busy, 1'b0);
    issue_miss(16'h0ABC);
    wait_idle();

    // Randomized fills: random addresses, keys, gaps with stray valids, mid-fill noise.
    for (int it = 0; it < 24; it++) begin
      wait_idle();
      miss_detected = 1'b0;
      n = $urandom_range(0, 4);
      for (int g = 0; g < n; g++) begin
        force_v = $urandom_range(0, 1) == 1;
        next_cycle();
      end
      force_v = 1'b0;
      key = 16'($urandom);
      issue_miss(16'($urandom));
      while (cyc < free_at) begin
        if ($urandom_range(0, 2) == 0) miss_address = 16'($urandom);
        miss_detected = $urandom_range(0, 1) == 1;
        next_cycle();
      end
      if ($urandom_range(0, 3) == 0) begin
        miss_detected = 1'b1;
        next_cycle();
      end
      miss_detected = 1'b0;
    end

    wait_idle();
    repeat (6) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
